// File: rtl/accum_mod_bank_if.sv
// Command, modulus-write and result buses of the modulo accumulator bank.
// slave = the bank, master = command source plus result consumer.
interface accum_mod_bank_if #(
  parameter int NCH = 4,
  parameter int W   = 16
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ch;
  logic [1:0]    in_op;
  logic [W-1:0]  in_data;
  logic          mod_we;
  logic [CW-1:0] mod_ch;
  logic [W-1:0]  mod_wdata;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ch;
  logic [W-1:0]  out_acc;
  logic          out_wrap;
  logic          out_err;

  modport slave (
    input  in_valid, in_ch, in_op, in_data, mod_we, mod_ch, mod_wdata, out_ready,
    output in_ready, out_valid, out_ch, out_acc, out_wrap, out_err
  );
  modport master (
    output in_valid, in_ch, in_op, in_data, mod_we, mod_ch, mod_wdata, out_ready,
    input  in_ready, out_valid, out_ch, out_acc, out_wrap, out_err
  );
endinterface

// File: rtl/accum_mod_bank.sv
// Bank of NCH modulo accumulators sharing one combinational datapath,
// with a single registered result stage (latency 1) and valid/ready flow control.
module accum_mod_bank_ch #(
  parameter int W       = 16,
  parameter int DEF_MOD = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         upd,
  input  logic [W-1:0] upd_val,
  input  logic         mwe,
  input  logic [W-1:0] mwdata,
  output logic [W-1:0] acc,
  output logic [W-1:0] mod
);
  // A modulus write wins over a same-edge command update and clears acc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      mod <= W'(DEF_MOD);
    end else if (mwe) begin
      acc <= '0;
      mod <= mwdata;
    end else if (upd) begin
      acc <= upd_val;
    end
  end
endmodule

module accum_mod_bank #(
  parameter int NCH     = 4,
  parameter int W       = 16,
  parameter int DEF_MOD = 100
) (
  input  logic            clk,
  input  logic            rst,
  accum_mod_bank_if.slave bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_LOAD = 2'd2, OP_CLR = 2'd3;

  logic [NCH-1:0][W-1:0] acc_q, mod_q;
  logic [W-1:0] acc_c, mod_c, res;
  logic [W:0]   a, d, me, sum, sub_fwd, sub_bwd;
  logic         ch_ok, err, wrap, accept, upd;

  always_comb begin
    acc_c = '0;
    mod_c = '0;
    ch_ok = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.in_ch == CW'(i)) begin
        acc_c = acc_q[i];
        mod_c = mod_q[i];
        ch_ok = 1'b1;
      end
    end
  end

  // Everything in W+1 bits so a stored modulus of 0 can stand for 2^W.
  assign a       = {1'b0, acc_c};
  assign d       = {1'b0, bus.in_data};
  assign me      = (mod_c == '0) ? {1'b1, {W{1'b0}}} : {1'b0, mod_c};
  assign sum     = a + d;
  assign sub_fwd = a - d;
  assign sub_bwd = a + me - d;

  always_comb begin
    res  = acc_c;
    wrap = 1'b0;
    err  = 1'b0;
    unique case (bus.in_op)
      OP_ADD: begin
        if (d >= me) err = 1'b1;
        else if (sum >= me) begin res = W'(sum - me); wrap = 1'b1; end
        else res = W'(sum);
      end
      OP_SUB: begin
        if (d >= me) err = 1'b1;
        else if (a >= d) res = W'(sub_fwd);
        else begin res = W'(sub_bwd); wrap = 1'b1; end
      end
      OP_LOAD: begin
        if (d >= me) err = 1'b1;
        else res = bus.in_data;
      end
      default: res = '0;
    endcase
    if (!ch_ok) begin
      res  = '0;
      wrap = 1'b0;
      err  = 1'b1;
    end
  end

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign upd          = accept && !err;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    accum_mod_bank_ch #(.W(W), .DEF_MOD(DEF_MOD)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .upd     (upd && (bus.in_ch == CW'(i))),
      .upd_val (res),
      .mwe     (bus.mod_we && (bus.mod_ch == CW'(i))),
      .mwdata  (bus.mod_wdata),
      .acc     (acc_q[i]),
      .mod     (mod_q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_ch    <= '0;
      bus.out_acc   <= '0;
      bus.out_wrap  <= 1'b0;
      bus.out_err   <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_ch    <= bus.in_ch;
      bus.out_acc   <= res;
      bus.out_wrap  <= wrap;
      bus.out_err   <= err;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_accum_mod_bank.sv
// Randomized and directed bench for accum_mod_bank against an arithmetic
// reference model of the channel values and the one-deep result register.
module tb_accum_mod_bank;
  localparam int NCH = 4, W = 16, DEF_MOD = 100;
  localparam int CW = 2;
  localparam int TWO_W = 1 << W;

  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, failures = 0;

  accum_mod_bank_if #(.NCH(NCH), .W(W)) bus ();
  accum_mod_bank #(.NCH(NCH), .W(W), .DEF_MOD(DEF_MOD)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // reference model state
  int m_acc [NCH];
  int m_mod [NCH];
  bit m_valid;
  int m_ch, m_res;
  bit m_wrap, m_err;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin m_acc[i] = 0; m_mod[i] = DEF_MOD; end
    m_valid = 0; m_ch = 0; m_res = 0; m_wrap = 0; m_err = 0;
  endfunction

  function automatic void model_cmd(input int ch, input int op, input int data);
    int me, s;
    me = (m_mod[ch] == 0) ? TWO_W : m_mod[ch];
    s = m_acc[ch]; m_wrap = 0; m_err = 0;
    case (op)
      0: if (data >= me) m_err = 1; else begin s = m_acc[ch] + data; if (s >= me) begin s -= me; m_wrap = 1; end end
      1: if (data >= me) m_err = 1; else if (m_acc[ch] >= data) s = m_acc[ch] - data;
         else begin s = m_acc[ch] + me - data; m_wrap = 1; end
      2: if (data >= me) m_err = 1; else s = data;
      default: s = 0;
    endcase
    m_acc[ch] = s;
    m_valid = 1; m_ch = ch; m_res = s;
  endfunction

  // One clock: drive, predict, advance, compare.
  task automatic step(input bit v, input int ch, input int op, input int data,
                      input bit mwe, input int mch, input int mdata, input bit ordy);
    bit exp_rdy;
    bus.in_valid = v; bus.in_ch = ch[CW-1:0]; bus.in_op = op[1:0]; bus.in_data = data[W-1:0];
    bus.mod_we = mwe; bus.mod_ch = mch[CW-1:0]; bus.mod_wdata = mdata[W-1:0];
    bus.out_ready = ordy;
    #1;
    exp_rdy = !m_valid || ordy;
    checks++;
    if (bus.in_ready !== exp_rdy) begin
      failures++; $display("FAIL in_ready: got %0b want %0b", bus.in_ready, exp_rdy);
    end
    if (v && exp_rdy) model_cmd(ch, op, data);
    else if (ordy) m_valid = 0;
    if (mwe) begin m_mod[mch] = mdata; m_acc[mch] = 0; end
    @(posedge clk); #1;
    bus.in_valid = 0; bus.mod_we = 0;
    checks++;
    if (bus.out_valid !== m_valid) begin
      failures++; $display("FAIL out_valid: got %0b want %0b", bus.out_valid, m_valid);
    end
    if (m_valid) begin
      checks++;
      if (bus.out_ch !== m_ch[CW-1:0] || int'(bus.out_acc) != m_res || bus.out_wrap !== m_wrap || bus.out_err !== m_err) begin
        failures++;
        $display("FAIL out_fields: got ch=%0d acc=%0d wrap=%0b err=%0b want ch=%0d acc=%0d wrap=%0b err=%0b",
                 bus.out_ch, bus.out_acc, bus.out_wrap, bus.out_err, m_ch, m_res, m_wrap, m_err);
      end
    end
  endtask

  task automatic cmd(input int ch, input int op, input int data);
    step(1, ch, op, data, 0, 0, 0, 1);
  endtask

  task automatic expect_out(input string name, input int acc, input bit wrap, input bit err);
    checks++;
    if (bus.out_valid !== 1'b1 || int'(bus.out_acc) != acc || bus.out_wrap !== wrap || bus.out_err !== err) begin
      failures++;
      $display("FAIL %s: got v=%0b acc=%0d wrap=%0b err=%0b want v=1 acc=%0d wrap=%0b err=%0b",
               name, bus.out_valid, bus.out_acc, bus.out_wrap, bus.out_err, acc, wrap, err);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_ch = 0; bus.in_op = 0; bus.in_data = 0;
    bus.mod_we = 0; bus.mod_ch = 0; bus.mod_wdata = 0; bus.out_ready = 1;
    rst = 1; model_reset();
    repeat (2) @(posedge clk);
    #1; rst = 0; #1;
    checks++;
    if (bus.out_valid !== 0 || bus.out_ch !== 0 || bus.out_acc !== 0 || bus.out_wrap !== 0 || bus.out_err !== 0 || bus.in_ready !== 1) begin
      failures++;
      $display("FAIL reset_state: got v=%0b ch=%0d acc=%0d wrap=%0b err=%0b rdy=%0b want all 0 and rdy=1",
               bus.out_valid, bus.out_ch, bus.out_acc, bus.out_wrap, bus.out_err, bus.in_ready);
    end
  endtask

  task automatic test_add_wrap();
    int exp_v [4] = '{30, 60, 90, 20};
    for (int i = 0; i < 4; i++) begin
      cmd(0, 0, 30);
      expect_out("add30", exp_v[i], i == 3, 0);
    end
  endtask

  task automatic test_full_range();
    step(0, 0, 0, 0, 1, 1, 0, 1);
    cmd(1, 2, 65530); expect_out("load65530", 65530, 0, 0);
    cmd(1, 0, 10);    expect_out("add_2w", 4, 1, 0);
    cmd(1, 1, 5);     expect_out("sub_2w", 65535, 1, 0);
  endtask

  task automatic test_small_mod();
    step(0, 0, 0, 0, 1, 2, 7, 1);
    cmd(2, 0, 7); expect_out("add_err", 0, 0, 1);
    cmd(2, 0, 6); expect_out("add6", 6, 0, 0);
    cmd(2, 1, 6); expect_out("sub6", 0, 0, 0);
    cmd(2, 2, 3); expect_out("load3", 3, 0, 0);
    cmd(2, 2, 9); expect_out("load_err", 3, 0, 1);
    cmd(2, 3, 0); expect_out("clr", 0, 0, 0);
    cmd(2, 1, 2); expect_out("sub_borrow", 5, 1, 0);
  endtask

  task automatic test_same_cycle();
    cmd(0, 2, 45);
    step(1, 0, 0, 10, 1, 0, 50, 1); expect_out("same_cycle", 55, 0, 0);
    cmd(0, 0, 10);                  expect_out("after_modwe", 10, 0, 0);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    step(1, 3, 0, 17, 0, 0, 0, 0);
    held = bus.out_acc;
    for (int i = 0; i < 3; i++) begin
      step(1, 3, 0, 5, 0, 0, 0, 0);
      checks++;
      if (bus.out_acc !== held || bus.in_ready !== 1'b0) begin
        failures++; $display("FAIL stall_hold: got acc=%0d rdy=%0b want acc=%0d rdy=0", bus.out_acc, bus.in_ready, held);
      end
    end
    for (int i = 0; i < 3; i++) step(1, 3, 0, 5, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      int ch, op, data, me, mch, mdata;
      bit v, mwe, ordy;
      ch = $urandom_range(0, NCH - 1);
      op = $urandom_range(0, 3);
      me = (m_mod[ch] == 0) ? TWO_W : m_mod[ch];
      data = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TWO_W - 1)) : int'($urandom_range(0, me - 1));
      v = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 2) != 0;
      mwe = $urandom_range(0, 15) == 0;
      mch = ($urandom_range(0, 1) == 1) ? ch : int'($urandom_range(0, NCH - 1));
      case ($urandom_range(0, 2))
        0: mdata = 0;
        1: mdata = $urandom_range(1, 20);
        default: mdata = $urandom_range(0, TWO_W - 1);
      endcase
      step(v, ch, op, data, mwe, mch, mdata, ordy);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_async_reset();
    step(1, 1, 2, 42, 0, 0, 0, 0);
    #2; rst = 1; #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL async_reset: got out_valid=%0b want 0", bus.out_valid);
    end
    model_reset();
    @(posedge clk); #1; rst = 0;
    for (int i = 0; i < NCH; i++) begin
      cmd(i, 0, 0); expect_out("post_rst_zero", 0, 0, 0);
    end
    cmd(1, 0, 100); expect_out("post_rst_mod", 0, 0, 1);
    cmd(1, 0, 99);  expect_out("post_rst_99", 99, 0, 0);
    cmd(1, 0, 1);   expect_out("post_rst_wrap", 0, 1, 0);
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_full_range();
    test_small_mod();
    test_same_cycle();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
